decode_stage_param: RTL and testbench
=====================================

DECODE_STAGE_PARAM -- requirements
Module: decode_stage_param

Interface
REQ-001 Parameter XLEN, default 32: datapath width of PC, register and immediate values.
REQ-002 Parameter CTRL_W, default 8: width of the decoded control bundle.
REQ-003 Parameter LOAD_BIT, default 0: index in the control bundle marking a load (ResultSrc = memory).
REQ-004 Parameter BYPASS, default 1: 1 enables write-through from W to D reads; 0 disables it.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 InstrD  in  32  D-stage instruction; rs1=[19:15], rs2=[24:20], rd=[11:7].
REQ-008 ValidD  in  1  D-stage instruction is real (not a bubble).
REQ-009 CtrlD  in  CTRL_W  decoded control bundle for InstrD.
REQ-010 ImmExtD  in  XLEN  sign-extended immediate for InstrD.
REQ-011 PCD, PCPlus4D  in  XLEN each  D-stage PC and PC+4.
REQ-012 StallE  in  1  hold ID/EX contents.
REQ-013 FlushE  in  1  replace ID/EX contents with a bubble.
REQ-014 RegWriteW  in  1; RDW  in  5; ResultW  in  XLEN  writeback port.
REQ-015 ValidE  out  1; CtrlE  out  CTRL_W; RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN; RS1_E, RS2_E, RD_E  out  5  ID/EX register contents.
REQ-016 LoadUseStallD  out  1  combinational load-use hazard request to F/D.
REQ-017 BubbleCount  out  16  saturating count of bubbles inserted.

Function
REQ-018 Register file: 32 x XLEN entries; x0 reads 0 always; write on rising edge when RegWriteW=1 and RDW!=0.
REQ-019 Reads combinational on rs1/rs2; when BYPASS=1, RegWriteW=1, RDW!=0 and RDW equals the read address, the read returns ResultW in the same cycle.
REQ-020 LoadUseStallD = ValidE & CtrlE[LOAD_BIT] & ValidD & RD_E!=0 & (RD_E==rs1 | RD_E==rs2).
REQ-021 ID/EX update priority per edge: rst, then FlushE, then StallE, then LoadUseStallD, then normal load.
REQ-022 FlushE=1: ValidE<=0, CtrlE<=0, RD_E/RS1_E/RS2_E<=0; data fields <=0.
REQ-023 StallE=1 and FlushE=0: all ID/EX fields hold, including ValidE.
REQ-024 LoadUseStallD=1 with no flush or stall: bubble inserted exactly as in REQ-022.
REQ-025 Normal load: ValidE<=ValidD; CtrlE<=CtrlD if ValidD else 0; RD1_E/RD2_E<=read data; Imm_Ext_E, PCE, PCPlus4E<=inputs; RD_E/RS1_E/RS2_E<=instruction fields.
REQ-026 Latency: D inputs appear on E outputs one cycle after capture; each stall cycle adds one.
REQ-027 BubbleCount increments by 1 on each edge where REQ-022 or REQ-024 applies and rst=0; it holds at 16'hFFFF.
REQ-028 Bubble-state instructions (ValidE=0) never raise LoadUseStallD.
REQ-029 Simultaneous write of register r at W and read of r at D, with BYPASS=1: captured RD1_E/RD2_E equals the new ResultW.

Reset
REQ-030 rst=1 at an edge clears all 32 registers, all ID/EX fields and BubbleCount to 0 and overrides every other input.
REQ-031 rst mid-stall or mid-hazard: state is 0 on the next edge; LoadUseStallD is 0 while ValidE=0.

Verification
REQ-032 Reset, write x5=0xDEADBEEF, then decode rs1=5 -> RD1_E=0xDEADBEEF one cycle later.
REQ-033 Write x0=0x1234 with RegWriteW=1, then read rs1=0 -> RD1_E=0; same-cycle bypass to x0 returns 0.
REQ-034 BYPASS=1: RDW=7, ResultW=0xA5A5A5A5, RegWriteW=1 while D reads rs2=7 -> RD2_E=0xA5A5A5A5 next cycle. BYPASS=0 -> RD2_E returns the old value.
REQ-035 E holds load with rd=3, D has rs1=3 -> LoadUseStallD=1; next cycle ValidE=0, CtrlE=0, BubbleCount=1.
REQ-036 StallE=1 for 3 cycles -> E outputs unchanged. FlushE=1 together with StallE=1 -> bubble inserted and BubbleCount increments.
REQ-037 Force 65540 flushes -> BubbleCount=16'hFFFF and stays there; rst=1 -> 0.

Source files
------------

// File: rtl/decode_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_param
// Brief    : RISC-V style decode stage: 32-entry register file with optional
//            W->D write-through, load-use hazard detect, ID/EX register and
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_param #(
    parameter int XLEN     = 32,
    parameter int CTRL_W   = 8,
    parameter int LOAD_BIT = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic              ValidD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [4:0]        RDW,
    input  logic [XLEN-1:0]   ResultW,
    output logic              ValidE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [4:0]        RS1_E,
    output logic [4:0]        RS2_E,
    output logic [4:0]        RD_E,
    output logic              LoadUseStallD,
    output logic [15:0]       BubbleCount
);

    localparam logic [4:0]  c_ZERO_REG = 5'd0;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [XLEN-1:0]   r_regs [32];

    logic              r_valid_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [XLEN-1:0]   r_rd1_e;
    logic [XLEN-1:0]   r_rd2_e;
    logic [XLEN-1:0]   r_imm_e;
    logic [XLEN-1:0]   r_pc_e;
    logic [XLEN-1:0]   r_pcp4_e;
    logic [4:0]        r_rs1_e;
    logic [4:0]        r_rs2_e;
    logic [4:0]        r_rd_e;
    logic [15:0]       r_bubble_cnt;

    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    logic              w_wr_en;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;
    logic              w_load_use;
    logic              w_bubble;
    logic              w_unused_bits;

    assign w_rs1   = InstrD[19:15];
    assign w_rs2   = InstrD[24:20];
    assign w_rd    = InstrD[11:7];
    assign w_wr_en = RegWriteW && (RDW != c_ZERO_REG);

    // Opcode/funct fields are decoded upstream into CtrlD.
    assign w_unused_bits = ^{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[RDW] <= ResultW;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            // Same-cycle writeback is visible to D reads (write-through).
            assign w_rd1 = (w_rs1 == c_ZERO_REG)              ? '0 :
                           (w_wr_en && (RDW == w_rs1))        ? ResultW :
                                                                r_regs[w_rs1];
            assign w_rd2 = (w_rs2 == c_ZERO_REG)              ? '0 :
                           (w_wr_en && (RDW == w_rs2))        ? ResultW :
                                                                r_regs[w_rs2];
        end else begin : g_no_bypass
            assign w_rd1 = (w_rs1 == c_ZERO_REG) ? '0 : r_regs[w_rs1];
            assign w_rd2 = (w_rs2 == c_ZERO_REG) ? '0 : r_regs[w_rs2];
        end
    endgenerate

    assign w_load_use = r_valid_e && r_ctrl_e[LOAD_BIT] && ValidD &&
                        (r_rd_e != c_ZERO_REG) &&
                        ((r_rd_e == w_rs1) || (r_rd_e == w_rs2));

    // Flush wins over stall; a load-use bubble only lands when E is not held.
    assign w_bubble = FlushE || (!StallE && w_load_use);

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid_e <= 1'b0;
            r_ctrl_e  <= '0;
            r_rd1_e   <= '0;
            r_rd2_e   <= '0;
            r_imm_e   <= '0;
            r_pc_e    <= '0;
            r_pcp4_e  <= '0;
            r_rs1_e   <= '0;
            r_rs2_e   <= '0;
            r_rd_e    <= '0;
        end else if (!StallE) begin
            r_valid_e <= ValidD;
            r_ctrl_e  <= ValidD ? CtrlD : '0;
            r_rd1_e   <= w_rd1;
            r_rd2_e   <= w_rd2;
            r_imm_e   <= ImmExtD;
            r_pc_e    <= PCD;
            r_pcp4_e  <= PCPlus4D;
            r_rs1_e   <= w_rs1;
            r_rs2_e   <= w_rs2;
            r_rd_e    <= w_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign ValidE        = r_valid_e;
    assign CtrlE         = r_ctrl_e;
    assign RD1_E         = r_rd1_e;
    assign RD2_E         = r_rd2_e;
    assign Imm_Ext_E     = r_imm_e;
    assign PCE           = r_pc_e;
    assign PCPlus4E      = r_pcp4_e;
    assign RS1_E         = r_rs1_e;
    assign RS2_E         = r_rs2_e;
    assign RD_E          = r_rd_e;
    assign LoadUseStallD = w_load_use;
    assign BubbleCount   = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_param
// Brief    : Vector table + scoreboard bench for decode_stage_param (BYPASS=1
//            and BYPASS=0 instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic        ValidD;
    logic [7:0]  CtrlD;
    logic [31:0] ImmExtD, PCD, PCPlus4D;
    logic        StallE, FlushE;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;

    logic        ValidE, LoadUseStallD;
    logic [7:0]  CtrlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic [15:0] BubbleCount;

    logic        nb_ValidE, nb_LoadUseStallD;
    logic [7:0]  nb_CtrlE;
    logic [31:0] nb_RD1_E, nb_RD2_E, nb_Imm_Ext_E, nb_PCE, nb_PCPlus4E;
    logic [4:0]  nb_RS1_E, nb_RS2_E, nb_RD_E;
    logic [15:0] nb_BubbleCount;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage_param #(.XLEN(32), .CTRL_W(8), .LOAD_BIT(0), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .CtrlD(CtrlD),
        .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .StallE(StallE),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .ValidE(ValidE), .CtrlE(CtrlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1_E(RS1_E),
        .RS2_E(RS2_E), .RD_E(RD_E), .LoadUseStallD(LoadUseStallD),
        .BubbleCount(BubbleCount)
    );

    decode_stage_param #(.XLEN(32), .CTRL_W(8), .LOAD_BIT(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .CtrlD(CtrlD),
        .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .StallE(StallE),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .ValidE(nb_ValidE), .CtrlE(nb_CtrlE), .RD1_E(nb_RD1_E), .RD2_E(nb_RD2_E),
        .Imm_Ext_E(nb_Imm_Ext_E), .PCE(nb_PCE), .PCPlus4E(nb_PCPlus4E),
        .RS1_E(nb_RS1_E), .RS2_E(nb_RS2_E), .RD_E(nb_RD_E),
        .LoadUseStallD(nb_LoadUseStallD), .BubbleCount(nb_BubbleCount)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic [4:0]  rs1, rs2, rd;
        logic        vld;
        logic [7:0]  ctrl;
        logic [31:0] imm, pc;
        logic [31:0] e_rd1, e_rd2, e_rd2nb;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [31:0] rd1, rd2, rd2nb, imm, pc, pcp4;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] mk_instr(input logic [4:0] rs1, rs2, rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_d(input logic [4:0] rs1, rs2, rd, input logic vld,
                           input logic [7:0] ctrl, input logic [31:0] imm, pc);
        InstrD   = mk_instr(rs1, rs2, rd);
        ValidD   = vld;
        CtrlD    = ctrl;
        ImmExtD  = imm;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic apply_w(input logic rw, input logic [4:0] rdw, input logic [31:0] res);
        RegWriteW = rw;
        RDW       = rdw;
        ResultW   = res;
    endtask

    task automatic push_exp(input logic [4:0] rs1, rs2, rd, input logic vld,
                            input logic [7:0] ctrl, input logic [31:0] imm, pc,
                            input logic [31:0] rd1, rd2, rd2nb);
        exp_t e;
        e.valid = vld;
        e.ctrl  = vld ? ctrl : 8'h00;
        e.rd1   = rd1;
        e.rd2   = rd2;
        e.rd2nb = rd2nb;
        e.imm   = imm;
        e.pc    = pc;
        e.pcp4  = pc + 32'd4;
        e.rs1   = rs1;
        e.rs2   = rs2;
        e.rd    = rd;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " ValidE"},    {31'd0, ValidE}, {31'd0, e.valid});
            chk({tag, " CtrlE"},     {24'd0, CtrlE},  {24'd0, e.ctrl});
            chk({tag, " RD1_E"},     RD1_E,           e.rd1);
            chk({tag, " RD2_E"},     RD2_E,           e.rd2);
            chk({tag, " nb_RD2_E"},  nb_RD2_E,        e.rd2nb);
            chk({tag, " Imm_Ext_E"}, Imm_Ext_E,       e.imm);
            chk({tag, " PCE"},       PCE,             e.pc);
            chk({tag, " PCPlus4E"},  PCPlus4E,        e.pcp4);
            chk({tag, " RS1_E"},     {27'd0, RS1_E},  {27'd0, e.rs1});
            chk({tag, " RS2_E"},     {27'd0, RS2_E},  {27'd0, e.rs2});
            chk({tag, " RD_E"},      {27'd0, RD_E},   {27'd0, e.rd});
        end
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0, 1'b0, 8'hFF, 32'h0000_0010, 32'h0000_1000,
                   32'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 5'd0, 32'h0000_1234, 5'd5, 5'd0, 5'd1, 1'b1, 8'h02, 32'h0000_0020, 32'h0000_1004,
                   32'hDEADBEEF, 32'h0, 32'h0};
        tbl[2] = '{1'b1, 5'd0, 32'h0000_5555, 5'd0, 5'd5, 5'd2, 1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0000_1008,
                   32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 5'd2, 1'b1, 8'h08, 32'h0000_0040, 32'h0000_100C,
                   32'hDEADBEEF, 32'hA5A5A5A5, 32'h0};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 5'd6, 1'b1, 8'h10, 32'h8000_0000, 32'h0000_1010,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[5] = '{1'b1, 5'd7, 32'h11112222, 5'd0, 5'd7, 5'd8, 1'b1, 8'h20, 32'h0000_0060, 32'h0000_1014,
                   32'h0, 32'h11112222, 32'hA5A5A5A5};
        tbl[6] = '{1'b1, 5'd3, 32'h33333333, 5'd0, 5'd0, 5'd3, 1'b1, 8'h01, 32'h0000_0070, 32'h0000_1018,
                   32'h0, 32'h0, 32'h0};

        rst = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        apply_w(1'b0, 5'd0, 32'h0);
        apply_d(5'd0, 5'd0, 5'd0, 1'b0, 8'h00, 32'h0, 32'h0);
        tick;
        tick;
        rst = 1'b0;

        chk("reset ValidE",        {31'd0, ValidE}, 32'd0);
        chk("reset CtrlE",         {24'd0, CtrlE},  32'd0);
        chk("reset RD1_E",         RD1_E,           32'd0);
        chk("reset PCE",           PCE,             32'd0);
        chk("reset BubbleCount",   {16'd0, BubbleCount}, 32'd0);
        chk("reset LoadUseStallD", {31'd0, LoadUseStallD}, 32'd0);

        // Table: regfile write/read, x0 handling, bypass vs no-bypass.
        for (int i = 0; i < 7; i++) begin
            apply_w(tbl[i].rw, tbl[i].rdw, tbl[i].resw);
            apply_d(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].vld, tbl[i].ctrl,
                    tbl[i].imm, tbl[i].pc);
            #1;
            chk($sformatf("vec%0d LoadUseStallD", i), {31'd0, LoadUseStallD}, 32'd0);
            push_exp(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].vld, tbl[i].ctrl,
                     tbl[i].imm, tbl[i].pc, tbl[i].e_rd1, tbl[i].e_rd2, tbl[i].e_rd2nb);
            tick;
            pop_check($sformatf("vec%0d", i));
        end
        chk("after table BubbleCount", {16'd0, BubbleCount}, 32'd0);

        // Load-use: E holds load to x3, D reads x3.
        apply_w(1'b0, 5'd0, 32'h0);
        apply_d(5'd3, 5'd0, 5'd4, 1'b1, 8'h02, 32'h0000_0080, 32'h0000_2000);
        #1;
        chk("hazard LoadUseStallD", {31'd0, LoadUseStallD}, 32'd1);
        tick;
        chk("hazard bubble ValidE",      {31'd0, ValidE}, 32'd0);
        chk("hazard bubble CtrlE",       {24'd0, CtrlE},  32'd0);
        chk("hazard bubble RD_E",        {27'd0, RD_E},   32'd0);
        chk("hazard bubble BubbleCount", {16'd0, BubbleCount}, 32'd1);
        chk("bubble no LoadUseStallD",   {31'd0, LoadUseStallD}, 32'd0);
        push_exp(5'd3, 5'd0, 5'd4, 1'b1, 8'h02, 32'h0000_0080, 32'h0000_2000,
                 32'h33333333, 32'h0, 32'h0);
        tick;
        pop_check("hazard replay");

        // Stall holds E for three cycles even while x5 is rewritten.
        apply_d(5'd5, 5'd7, 5'd9, 1'b1, 8'h10, 32'hFFFF_FFF0, 32'h0000_0100);
        push_exp(5'd5, 5'd7, 5'd9, 1'b1, 8'h10, 32'hFFFF_FFF0, 32'h0000_0100,
                 32'hDEADBEEF, 32'h11112222, 32'h11112222);
        tick;
        pop_check("pre-stall");
        StallE = 1'b1;
        apply_w(1'b1, 5'd5, 32'h0BADF00D);
        apply_d(5'd7, 5'd0, 5'd11, 1'b1, 8'h20, 32'h0, 32'h0000_0200);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk($sformatf("stall%0d RD1_E", c),     RD1_E,     32'hDEADBEEF);
            chk($sformatf("stall%0d PCE", c),       PCE,       32'h0000_0100);
            chk($sformatf("stall%0d Imm_Ext_E", c), Imm_Ext_E, 32'hFFFF_FFF0);
            chk($sformatf("stall%0d ValidE", c),    {31'd0, ValidE}, 32'd1);
            chk($sformatf("stall%0d RD_E", c),      {27'd0, RD_E},   32'd9);
            chk($sformatf("stall%0d BubbleCount", c), {16'd0, BubbleCount}, 32'd1);
        end
        apply_w(1'b0, 5'd0, 32'h0);
        FlushE = 1'b1;
        tick;
        chk("flush+stall ValidE",      {31'd0, ValidE}, 32'd0);
        chk("flush+stall CtrlE",       {24'd0, CtrlE},  32'd0);
        chk("flush+stall PCE",         PCE,             32'd0);
        chk("flush+stall RD1_E",       RD1_E,           32'd0);
        chk("flush+stall BubbleCount", {16'd0, BubbleCount}, 32'd2);
        FlushE = 1'b0;
        StallE = 1'b0;
        apply_d(5'd5, 5'd0, 5'd12, 1'b1, 8'h02, 32'h0000_0005, 32'h0000_0300);
        push_exp(5'd5, 5'd0, 5'd12, 1'b1, 8'h02, 32'h0000_0005, 32'h0000_0300,
                 32'h0BADF00D, 32'h0, 32'h0);
        tick;
        pop_check("post-stall");

        // Reset in the middle of a pending load-use hazard.
        apply_d(5'd0, 5'd0, 5'd5, 1'b1, 8'h01, 32'h0, 32'h0000_0400);
        push_exp(5'd0, 5'd0, 5'd5, 1'b1, 8'h01, 32'h0, 32'h0000_0400, 32'h0, 32'h0, 32'h0);
        tick;
        pop_check("load x5");
        apply_d(5'd0, 5'd5, 5'd6, 1'b1, 8'h02, 32'h0, 32'h0000_0404);
        #1;
        chk("pre-rst LoadUseStallD", {31'd0, LoadUseStallD}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst mid-hazard ValidE",        {31'd0, ValidE}, 32'd0);
        chk("rst mid-hazard BubbleCount",   {16'd0, BubbleCount}, 32'd0);
        chk("rst mid-hazard LoadUseStallD", {31'd0, LoadUseStallD}, 32'd0);
        push_exp(5'd0, 5'd5, 5'd6, 1'b1, 8'h02, 32'h0, 32'h0000_0404, 32'h0, 32'h0, 32'h0);
        tick;
        pop_check("regs cleared");

        // Saturation: 65540 flushes in total.
        FlushE = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat 65534 BubbleCount", {16'd0, BubbleCount}, 32'h0000_FFFE);
        chk("sat flush ValidE",      {31'd0, ValidE}, 32'd0);
        tick;
        chk("sat 65535 BubbleCount", {16'd0, BubbleCount}, 32'h0000_FFFF);
        repeat (5) tick;
        chk("sat 65540 BubbleCount", {16'd0, BubbleCount}, 32'h0000_FFFF);
        FlushE = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("sat rst BubbleCount",   {16'd0, BubbleCount}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
